// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and constants for the LVDS ADC capture path.
package adc_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        PICK = 2'd0,
        SUM  = 2'd1,
        MAX  = 2'd2,
        MIN  = 2'd3
    } mode_e;

    localparam int IRQ_DONE    = 0;
    localparam int IRQ_OVERRUN = 1;

    localparam logic [31:0] IRQ_SELF_PATTERN = 32'h0000_000F;

endpackage

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: appends decimated frames to a bit accumulator and
// emits one dense RAM word whenever a full word's worth of bits is present.
module adc_frame_packer #(
    parameter int IN_W   = 96,
    parameter int WORD_W = 128
) (
    input  logic              adc_clkinp,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    localparam int ACC_W  = WORD_W + IN_W;
    localparam int FILL_W = $clog2(ACC_W + 1);

    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  cat;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_nxt;

    // Fill stays below WORD_W between groups, so one emit per group suffices.
    always_comb begin
        cat      = acc_q | (ACC_W'(in_data) << fill_q);
        fill_nxt = fill_q + FILL_W'(IN_W);
    end

    always_ff @(posedge adc_clkinp) begin
        if (rst) begin
            acc_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                if (fill_nxt >= FILL_W'(WORD_W)) begin
                    out_valid <= 1'b1;
                    out_data  <= cat[WORD_W-1:0];
                    acc_q     <= cat >> WORD_W;
                    fill_q    <= fill_nxt - FILL_W'(WORD_W);
                end else begin
                    acc_q  <= cat;
                    fill_q <= fill_nxt;
                end
            end
        end
    end

endmodule

// File: rtl/adc_capture_engine.sv
// adc_capture_engine: triggered capture of ADC frames with per-channel
// decimation, slot or bit-packed RAM writes and done/overrun interrupts.
module adc_capture_engine
    import adc_capture_pkg::*;
#(
    parameter int NCH      = 8,
    parameter int SAMPLE_W = 12,
    parameter int SLOT_W   = 16,
    parameter int WORD_W   = NCH * SLOT_W,
    parameter int ADDR_W   = 15,
    parameter int DIV_W    = 4,
    parameter int RECLEN_W = 16
) (
    input  logic                    adc_clkinp,
    input  logic                    iStateReset,
    input  logic [NCH*SAMPLE_W-1:0] iSampleData,
    input  logic                    iSampleValid,
    input  logic [DIV_W-1:0]        iDivisor,
    input  logic [1:0]              iMode,
    input  logic [2:0]              iShift,
    input  logic                    iPack,
    input  logic                    iIrqSelf,
    input  logic [RECLEN_W-1:0]     iRecLength,
    input  logic                    itxTrig,
    output logic                    otxTrigAck,
    output logic [31:0]             oRcvInterrupt,
    output logic                    oWREN,
    output logic                    oCLKEN,
    output logic                    oCHIPSEL,
    output logic [WORD_W/8-1:0]     oBYTEEN,
    output logic [ADDR_W-1:0]       oWAddr,
    output logic [WORD_W-1:0]       oADCData
);

    localparam int IN_W  = NCH * SAMPLE_W;
    localparam int SUM_W = SAMPLE_W + DIV_W;
    localparam logic [SUM_W-1:0] SAT = {{DIV_W{1'b0}}, {SAMPLE_W{1'b1}}};

    state_e              st_q;
    state_e              st_nxt;
    logic [DIV_W-1:0]    div_q;
    mode_e               mode_q;
    logic [2:0]          shift_q;
    logic                pack_q;
    logic                irq_self_q;

    logic                trig_q;
    logic [DIV_W-1:0]    grp_q;
    logic [SUM_W-1:0]    acc_q   [NCH];
    logic [SUM_W-1:0]    acc_nxt [NCH];
    logic [SUM_W-1:0]    sx;
    logic [SUM_W-1:0]    shv;
    logic [IN_W-1:0]     res;
    logic [WORD_W-1:0]   up_word;
    logic [WORD_W-1:0]   up_word_q;
    logic                up_valid_q;
    logic                pk_valid;
    logic [WORD_W-1:0]   pk_word;

    logic [ADDR_W-1:0]   addr_q;
    logic [RECLEN_W-1:0] cnt_q;
    logic                done_q;
    logic                ovr_q;
    logic [31:0]         irq_vec;

    logic cap;
    logic trig_edge;
    logic take;
    logic grp_done;
    logic wr;
    logic cnt_hit;
    logic addr_end;

    assign cap       = (st_q == CAPTURE);
    assign trig_edge = itxTrig & ~trig_q;
    assign take      = cap & iSampleValid;
    assign grp_done  = take && (grp_q == div_q);
    assign wr        = (pack_q ? pk_valid : up_valid_q) & cap;
    assign cnt_hit   = ((cnt_q + 1'b1) == iRecLength);
    assign addr_end  = &addr_q;

    always_ff @(posedge adc_clkinp) begin
        if (iStateReset) st_q <= IDLE;
        else             st_q <= st_nxt;
    end

    always_comb begin
        st_nxt = st_q;
        unique case (st_q)
            IDLE:    if (trig_edge) st_nxt = CAPTURE;
            CAPTURE: begin
                if (iRecLength == '0 || (wr && (cnt_hit || addr_end)))
                    st_nxt = DONE;
            end
            DONE:    st_nxt = DONE;
            default: st_nxt = IDLE;
        endcase
    end

    // The first frame of a group seeds the accumulator in every mode.
    always_comb begin
        sx  = '0;
        shv = '0;
        res = '0;
        for (int k = 0; k < NCH; k++) begin
            sx = {{DIV_W{1'b0}}, iSampleData[k*SAMPLE_W +: SAMPLE_W]};
            acc_nxt[k] = acc_q[k];
            unique case (mode_q)
                PICK: acc_nxt[k] = acc_q[k];
                SUM:  acc_nxt[k] = acc_q[k] + sx;
                MAX:  acc_nxt[k] = (sx > acc_q[k]) ? sx : acc_q[k];
                MIN:  acc_nxt[k] = (sx < acc_q[k]) ? sx : acc_q[k];
            endcase
            if (grp_q == '0) acc_nxt[k] = sx;
            shv = acc_nxt[k] >> shift_q;
            if (mode_q == SUM)
                res[k*SAMPLE_W +: SAMPLE_W] = (shv > SAT) ? SAT[SAMPLE_W-1:0]
                                                          : shv[SAMPLE_W-1:0];
            else
                res[k*SAMPLE_W +: SAMPLE_W] = acc_nxt[k][SAMPLE_W-1:0];
        end
    end

    always_comb begin
        up_word = '0;
        for (int k = 0; k < NCH; k++)
            up_word[k*SLOT_W +: SLOT_W] = SLOT_W'(res[k*SAMPLE_W +: SAMPLE_W]);
    end

    always_ff @(posedge adc_clkinp) begin
        if (iStateReset) begin
            div_q      <= iDivisor;
            mode_q     <= mode_e'(iMode);
            shift_q    <= iShift;
            pack_q     <= iPack;
            irq_self_q <= iIrqSelf;
            trig_q     <= 1'b0;
            grp_q      <= '0;
            for (int k = 0; k < NCH; k++) acc_q[k] <= '0;
            up_valid_q <= 1'b0;
            up_word_q  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            trig_q     <= itxTrig;
            up_valid_q <= grp_done & ~pack_q;
            if (grp_done & ~pack_q) up_word_q <= up_word;
            if (take) begin
                grp_q <= grp_done ? '0 : grp_q + 1'b1;
                for (int k = 0; k < NCH; k++) acc_q[k] <= acc_nxt[k];
            end
            if (st_q == IDLE && trig_edge) begin
                addr_q <= '0;
                cnt_q  <= '0;
            end else if (wr) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
            if (cap && st_nxt == DONE) begin
                done_q <= 1'b1;
                ovr_q  <= wr && addr_end && !cnt_hit;
            end
        end
    end

    adc_frame_packer #(
        .IN_W   (IN_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .adc_clkinp (adc_clkinp),
        .rst        (iStateReset),
        .in_valid   (grp_done & pack_q),
        .in_data    (res),
        .out_valid  (pk_valid),
        .out_data   (pk_word)
    );

    always_comb begin
        irq_vec              = '0;
        irq_vec[IRQ_DONE]    = done_q;
        irq_vec[IRQ_OVERRUN] = ovr_q;
    end

    assign oRcvInterrupt = iStateReset ? (irq_self_q ? IRQ_SELF_PATTERN : 32'h0)
                                       : irq_vec;
    assign otxTrigAck = cap;
    assign oCLKEN     = cap;
    assign oCHIPSEL   = cap;
    assign oBYTEEN    = {(WORD_W/8){cap}};
    assign oWREN      = wr;
    assign oWAddr     = addr_q;
    assign oADCData   = pack_q ? pk_word : up_word_q;

endmodule

// File: tb/tb_adc_capture_engine.sv
// tb_adc_capture_engine: directed and randomized captures checked against
// a frame-level reference model; a second instance uses a 4-bit address.
`timescale 1ns/1ps
module tb_adc_capture_engine;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [95:0]  data;
    logic         vld;
    logic [3:0]   div;
    logic [1:0]   mode;
    logic [2:0]   shift;
    logic         pack;
    logic         irqs;
    logic [15:0]  reclen;
    logic         trig;

    logic         ack0, wren0, clken0, cs0;
    logic [31:0]  irq0;
    logic [15:0]  be0;
    logic [14:0]  addr0;
    logic [127:0] dat0;

    logic         ack1, wren1, clken1, cs1;
    logic [31:0]  irq1;
    logic [15:0]  be1;
    logic [3:0]   addr1;
    logic [127:0] dat1;

    adc_capture_engine u_dut (
        .adc_clkinp (clk), .iStateReset (rst), .iSampleData (data),
        .iSampleValid (vld), .iDivisor (div), .iMode (mode), .iShift (shift),
        .iPack (pack), .iIrqSelf (irqs), .iRecLength (reclen), .itxTrig (trig),
        .otxTrigAck (ack0), .oRcvInterrupt (irq0), .oWREN (wren0),
        .oCLKEN (clken0), .oCHIPSEL (cs0), .oBYTEEN (be0), .oWAddr (addr0),
        .oADCData (dat0)
    );

    adc_capture_engine #(.ADDR_W(4)) u_small (
        .adc_clkinp (clk), .iStateReset (rst), .iSampleData (data),
        .iSampleValid (vld), .iDivisor (div), .iMode (mode), .iShift (shift),
        .iPack (pack), .iIrqSelf (irqs), .iRecLength (reclen), .itxTrig (trig),
        .otxTrigAck (ack1), .oRcvInterrupt (irq1), .oWREN (wren1),
        .oCLKEN (clken1), .oCHIPSEL (cs1), .oBYTEEN (be1), .oWAddr (addr1),
        .oADCData (dat1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         mon;
    logic [127:0] wd0[$], wd1[$];
    int           wa0[$], wa1[$];
    int           last0, last1, done0, done1, capc, bad0, bad1;

    always @(negedge clk) begin
        if (!mon) begin
            wd0.delete(); wd1.delete(); wa0.delete(); wa1.delete();
            last0 <= -1; last1 <= -1; done0 <= -1; done1 <= -1;
            capc <= -1; bad0 <= 0; bad1 <= 0;
        end else begin
            if (wren0) begin
                wd0.push_back(dat0); wa0.push_back(int'(addr0)); last0 <= cyc;
            end
            if (wren1) begin
                wd1.push_back(dat1); wa1.push_back(int'(addr1)); last1 <= cyc;
            end
            if (irq0[0] && done0 < 0) done0 <= cyc;
            if (irq1[0] && done1 < 0) done1 <= cyc;
            if (wren0 && !ack0) bad0 <= bad0 + 1;
            if (wren1 && !ack1) bad1 <= bad1 + 1;
            if (ack0 && capc < 0) capc <= cyc;
        end
    end

    logic [95:0]  sf[$];
    bit           sv[$];
    logic [127:0] ew[$];
    bit           bq[$];

    function automatic int chan(input logic [95:0] f, input int k);
        return int'(f[k*12 +: 12]);
    endfunction

    // Reference: group accepted frames, reduce per channel, then lay out words.
    function automatic void build_model(input int d, input int m,
                                        input int sh, input int pk);
        logic [95:0]  acc[$];
        logic [95:0]  r;
        logic [127:0] w;
        int           nd, v, c;
        ew.delete();
        bq.delete();
        foreach (sf[i]) if (sv[i]) acc.push_back(sf[i]);
        nd = d + 1;
        for (int g = 0; (g + 1) * nd <= acc.size(); g++) begin
            r = '0;
            for (int k = 0; k < 8; k++) begin
                v = chan(acc[g*nd], k);
                if (m == 1) begin
                    for (int j = 1; j < nd; j++) v += chan(acc[g*nd+j], k);
                    v = v >> sh;
                    if (v > 4095) v = 4095;
                end else if (m >= 2) begin
                    for (int j = 1; j < nd; j++) begin
                        c = chan(acc[g*nd+j], k);
                        if ((m == 2 && c > v) || (m == 3 && c < v)) v = c;
                    end
                end
                r[k*12 +: 12] = v[11:0];
            end
            if (pk == 0) begin
                w = '0;
                for (int k = 0; k < 8; k++) w[k*16 +: 16] = {4'b0, r[k*12 +: 12]};
                ew.push_back(w);
            end else begin
                for (int i = 0; i < 96; i++) bq.push_back(r[i]);
                if (bq.size() >= 128) begin
                    for (int i = 0; i < 128; i++) w[i] = bq.pop_front();
                    ew.push_back(w);
                end
            end
        end
    endfunction

    task automatic verify(input string tag, input int d, input int aw, input int rl);
        logic [127:0] q[$];
        int           a[$];
        int           lst, dn, bad, n_exp, lim;
        logic [31:0]  irq;
        bit           e_done, e_ovr;
        if (d == 0) begin
            q = wd0; a = wa0; lst = last0; dn = done0; bad = bad0; irq = irq0;
        end else begin
            q = wd1; a = wa1; lst = last1; dn = done1; bad = bad1; irq = irq1;
        end
        lim   = 1 << aw;
        n_exp = rl;
        if (ew.size() < n_exp) n_exp = ew.size();
        if (lim < n_exp) n_exp = lim;
        e_done = (rl == 0) || (ew.size() >= rl) || (ew.size() >= lim);
        e_ovr  = (rl > lim) && (ew.size() >= lim);
        chk({tag, " nwr"}, q.size(), n_exp);
        for (int i = 0; i < q.size() && i < n_exp; i++) begin
            chk($sformatf("%s addr%0d", tag, i), a[i], i);
            chk($sformatf("%s data%0d", tag, i), q[i], ew[i]);
        end
        chk({tag, " irq"}, irq, {30'b0, e_ovr, e_done});
        chk({tag, " wr_out_cap"}, bad, 0);
        if (e_done) begin
            if (n_exp > 0) chk({tag, " done_t"}, dn, lst + 1);
            else           chk({tag, " done_t0"}, dn, capc + 1);
        end
    endtask

    task automatic run(input string tag, input int d, input int m,
                       input int sh, input int pk, input int rl);
        div = 4'(d); mode = 2'(m); shift = 3'(sh); pack = pk[0];
        reclen = 16'(rl); irqs = 1'b0; trig = 1'b0; vld = 1'b0;
        rst = 1'b1; mon = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " rst wren"}, wren0, 0);
        chk({tag, " rst addr"}, addr0, 0);
        rst = 1'b0;
        @(negedge clk);
        mon  = 1'b1;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        chk({tag, " ack"}, {ack0, clken0, cs0, be0}, {3'b111, 16'hFFFF});
        foreach (sf[i]) begin
            data = sf[i];
            vld  = sv[i];
            @(negedge clk);
        end
        vld = 1'b0;
        repeat (12) @(negedge clk);
        build_model(d, m, sh, pk);
        verify({tag, "/A15"}, 0, 15, rl);
        verify({tag, "/A4"}, 1, 4, rl);
    endtask

    function automatic logic [95:0] rnd_frame();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [95:0] ch0_frame(input int v);
        logic [95:0] f;
        f = '0;
        f[11:0] = v[11:0];
        return f;
    endfunction

    logic [95:0] f;
    int          d, m, rl, nf;

    initial begin
        rst = 1'b1; data = '0; vld = 1'b0; div = '0; mode = '0; shift = '0;
        pack = 1'b0; irqs = 1'b0; reclen = '0; trig = 1'b0; mon = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset outs", {ack0, wren0, clken0, cs0, be0, addr0, irq0},
            '0);
        chk("reset data", dat0, '0);

        sf.delete(); sv.delete();
        for (int n = 0; n < 6; n++) begin
            f = '0;
            for (int k = 0; k < 8; k++) f[k*12 +: 12] = 12'(100 * k + n);
            sf.push_back(f); sv.push_back(1'b1);
        end
        run("pick", 0, 0, 0, 0, 4);
        chk("pick w1s2", wd0.size() > 1 ? wd0[1][47:32] : 16'hFFFF, 16'd201);

        sf.delete(); sv.delete();
        sf.push_back(ch0_frame(10));  sv.push_back(1'b1);
        sf.push_back(ch0_frame(20));  sv.push_back(1'b1);
        sf.push_back(ch0_frame(30));  sv.push_back(1'b1);
        sf.push_back(ch0_frame(999)); sv.push_back(1'b0);
        sf.push_back(ch0_frame(40));  sv.push_back(1'b1);
        run("sum", 3, 1, 2, 0, 1);
        chk("sum ch0", wd0.size() > 0 ? wd0[0][15:0] : 16'hFFFF, 16'd25);

        sf.delete(); sv.delete();
        for (int n = 0; n < 4; n++) begin sf.push_back({8{12'hFFF}}); sv.push_back(1'b1); end
        run("sat", 3, 1, 0, 0, 1);
        chk("sat ch0", wd0.size() > 0 ? wd0[0][15:0] : 16'h0, 16'd4095);

        sf.delete(); sv.delete();
        sf.push_back(ch0_frame(7)); sv.push_back(1'b1);
        sf.push_back(ch0_frame(3)); sv.push_back(1'b1);
        run("max", 1, 2, 0, 0, 1);
        chk("max ch0", wd0.size() > 0 ? wd0[0][15:0] : 16'h0, 16'd7);
        run("min", 1, 3, 0, 0, 1);
        chk("min ch0", wd0.size() > 0 ? wd0[0][15:0] : 16'h0, 16'd3);

        sf.delete(); sv.delete();
        for (int n = 0; n < 4; n++) begin sf.push_back(rnd_frame()); sv.push_back(1'b1); end
        run("pack", 0, 0, 0, 1, 3);
        chk("pack w0hi", wd0.size() > 0 ? wd0[0][127:96] : '0, sf[1][31:0]);
        chk("pack w2", wd0.size() > 2 ? wd0[2] : '0, {sf[3], sf[2][95:64]});

        sf.delete(); sv.delete();
        for (int n = 0; n < 25; n++) begin sf.push_back(rnd_frame()); sv.push_back(1'b1); end
        run("ovr", 0, 0, 0, 0, 20);
        chk("ovr small irq", irq1, 32'h3);

        div = '0; mode = '0; shift = '0; pack = 1'b0; reclen = 16'd100;
        irqs = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; @(negedge clk);
        trig = 1'b1; @(negedge clk);
        trig = 1'b0; data = rnd_frame(); vld = 1'b1; @(negedge clk);
        data = rnd_frame(); @(negedge clk);
        rst = 1'b1; vld = 1'b0; @(negedge clk);
        chk("midrst ctl", {ack0, wren0, clken0, cs0, be0}, '0);
        chk("midrst addr", addr0, 0);
        chk("midrst data", dat0, 0);
        chk("midrst irq", irq0, 0);

        irqs = 1'b1;
        repeat (2) @(negedge clk);
        chk("irqself A15", irq0, 32'hF);
        chk("irqself A4", irq1, 32'hF);
        irqs = 1'b0;
        repeat (2) @(negedge clk);
        chk("irqself off", irq0, 32'h0);

        for (int it = 0; it < 20; it++) begin
            d  = $urandom_range(0, 15);
            m  = $urandom_range(0, 3);
            rl = $urandom_range(0, 12);
            nf = (3 * rl + 3) * (d + 1);
            sf.delete(); sv.delete();
            for (int n = 0; n < nf; n++) begin
                sf.push_back(rnd_frame());
                sv.push_back($urandom_range(0, 3) != 0);
            end
            run($sformatf("rnd%0d", it), d, m, $urandom_range(0, 7),
                $urandom_range(0, 1), rl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
